// File: rtl/neurorisc_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : neurorisc_mem_pkg
//  Description : Shared definitions for the core-to-memory arbitration path.
//                Provides the default bus widths, the arbiter state encoding
//                and a small request-eligibility helper.
//  Contents    : c_DEF_ADDR_W  default address width
//                c_DEF_DATA_W  default data width
//                arb_state_t   ARB_IDLE / ARB_FETCH / ARB_DATA (2-bit)
//                req_eligible  request is live and not completing this cycle
//  Revision    : 1.0  initial release
// ============================================================================
package neurorisc_mem_pkg;

    localparam int unsigned c_DEF_ADDR_W = 32;
    localparam int unsigned c_DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_t;

    // A requester holds req high until it sees its done pulse, so during the
    // done cycle its req is stale and must not win a new grant.
    function automatic logic req_eligible(input logic req, input logic done);
        return req & ~done;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : mem_timeout_ctr
//  Description : Bus-transaction watchdog. Counts enabled cycles since the
//                last load and raises tc on the TIMEOUT-th enabled cycle, so
//                an owner that aborts on tc holds the bus for exactly TIMEOUT
//                cycles. TIMEOUT = 0 disables tc entirely.
//  Ports       : clk     in   clock, rising edge
//                rst_n   in   asynchronous active-low reset
//                load    in   restart the count (transaction granted)
//                enable  in   count this cycle (transaction outstanding)
//                tc      out  terminal count reached this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic tc
);

    // The count only needs to reach TIMEOUT-1.
    localparam int unsigned c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST =
        c_CNT_W'((TIMEOUT == 0) ? 0 : (TIMEOUT - 1));
    localparam logic c_ENABLED = (TIMEOUT != 0);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= '0;
        end else if (enable) begin
            // Wrap is harmless: the owner leaves the counting state on tc.
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign tc = c_ENABLED & enable & (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported memory bus between the instruction
//                fetch port and the load/store port. A granted transaction
//                owns the bus until mem_ready (or a timeout abort). Data wins
//                ties, except that fetch is forced after STARVE_MAX data grants
//                made while a fetch was waiting. mem_wait stalls the control
//                FSM while any transaction is pending or outstanding.
//  Ports       : clk, reset_in_n           clock / async active-low reset
//                if_req/if_addr            fetch request in
//                if_rdata/if_done          fetch result out (done = 1 cycle)
//                d_req/d_we/d_addr/
//                d_wdata/d_wstrb           load/store request in
//                d_rdata/d_done            load result out (done = 1 cycle)
//                mem_req/mem_we/mem_addr/
//                mem_wdata/mem_wstrb       registered bus request out
//                mem_ready/mem_rdata       bus response in
//                mem_wait                  combinational stall out
//                bus_err                   sticky timeout flag out
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import neurorisc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = c_DEF_ADDR_W,
    parameter int unsigned DATA_W     = c_DEF_DATA_W,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset_in_n,
    // instruction fetch port
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    // load/store port
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_done,
    // memory bus
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    // control
    output logic                mem_wait,
    output logic                bus_err
);

    localparam int unsigned c_STRB_W   = DATA_W / 8;
    localparam int unsigned c_STARVE_W =
        (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [c_STARVE_W-1:0] c_STARVE_LIM = c_STARVE_W'(STARVE_MAX);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [c_STARVE_W-1:0]  r_starve;

    logic w_if_elig;
    logic w_d_elig;
    logic w_force_fetch;
    logic w_grant_fetch;
    logic w_grant_data;
    logic w_complete;
    logic w_abort;
    logic w_finish;
    logic w_busy;
    logic w_timeout;

    assign w_if_elig     = req_eligible(if_req, if_done);
    assign w_d_elig      = req_eligible(d_req, d_done);
    assign w_force_fetch = w_if_elig & (r_starve == c_STARVE_LIM);
    assign w_busy        = (r_state != ARB_IDLE);
    assign w_finish      = w_complete | w_abort;

    assign mem_wait = w_busy | (if_req & ~if_done) | (d_req & ~d_done);

    // ------------------------------------------------------------------
    // Transaction watchdog: restarted on every grant, counts while busy.
    // ------------------------------------------------------------------
    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (reset_in_n),
        .load   (w_grant_fetch | w_grant_data),
        .enable (w_busy),
        .tc     (w_timeout)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_in_n) begin
        if (!reset_in_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and grant/finish decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_fetch = 1'b0;
        w_grant_data  = 1'b0;
        w_complete    = 1'b0;
        w_abort       = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_d_elig && !w_force_fetch) begin
                    w_grant_data = 1'b1;
                    w_state_nxt  = ARB_DATA;
                end else if (w_if_elig) begin
                    w_grant_fetch = 1'b1;
                    w_state_nxt   = ARB_FETCH;
                end
            end
            ARB_FETCH, ARB_DATA: begin
                // A response on the terminal-count edge is a normal completion.
                if (mem_ready) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end else if (w_timeout) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus request fields, latched once at grant and held while busy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_in_n) begin
        if (!reset_in_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            mem_req <= (w_state_nxt != ARB_IDLE);
            if (w_grant_data) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_wstrb <= d_we ? d_wstrb : {c_STRB_W{1'b0}};
            end else if (w_grant_fetch) begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_wstrb <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Completion: done pulses, read data capture, sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_in_n) begin
        if (!reset_in_n) begin
            if_done  <= 1'b0;
            d_done   <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
            bus_err  <= 1'b0;
        end else begin
            if_done <= w_finish & (r_state == ARB_FETCH);
            d_done  <= w_finish & (r_state == ARB_DATA);
            if (w_finish && (r_state == ARB_FETCH)) begin
                if_rdata <= w_complete ? mem_rdata : '0;
            end
            // Stores never touch the load result register.
            if (w_finish && (r_state == ARB_DATA) && !mem_we) begin
                d_rdata <= w_complete ? mem_rdata : '0;
            end
            if (w_abort) begin
                bus_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: data grants made while a fetch is waiting
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_in_n) begin
        if (!reset_in_n) begin
            r_starve <= '0;
        end else if (w_grant_fetch) begin
            r_starve <= '0;
        end else if (w_grant_data && if_req && (r_starve != c_STARVE_LIM)) begin
            r_starve <= r_starve + c_STARVE_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter
//                (TIMEOUT = 8, STARVE_MAX = 4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset_in_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_wait;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .TIMEOUT    (8),
        .STARVE_MAX (4)
    ) dut (
        .clk        (clk),
        .reset_in_n (reset_in_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_done    (if_done),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wstrb    (d_wstrb),
        .d_rdata    (d_rdata),
        .d_done     (d_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .mem_wait   (mem_wait),
        .bus_err    (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    logic [6:0] order;
    int         n_grants;
    int         n_ddone;
    logic       fetch_done;
    logic       prev_req;

    initial begin
        reset_in_n = 1'b0;
        if_req     = 1'b0;
        if_addr    = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        d_wstrb    = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;

        // ---------------- reset state ----------------
        #12;
        check_val("rst_mem_req",  mem_req,  0);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_done",     {if_done, d_done}, 0);
        check_val("rst_bus_err",  bus_err,  0);
        check_val("rst_mem_wait", mem_wait, 0);
        reset_in_n = 1'b1;
        step();

        // ---------------- 1: single fetch ----------------
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        #1;
        check_val("t1_wait_pre", mem_wait, 1);
        step();
        check_val("t1_mem_req",   mem_req,   1);
        check_val("t1_mem_addr",  mem_addr,  32'h100);
        check_val("t1_mem_wstrb", mem_wstrb, 0);
        check_val("t1_mem_we",    mem_we,    0);
        check_val("t1_if_done0",  if_done,   0);
        mem_ready = 1'b1;
        mem_rdata = 32'h0050_0093;
        step();
        check_val("t1_if_done",  if_done,  1);
        check_val("t1_if_rdata", if_rdata, 32'h0050_0093);
        check_val("t1_req_drop", mem_req,  0);
        if_req    = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        step();
        check_val("t1_done_pulse", if_done,  0);
        check_val("t1_rdata_held", if_rdata, 32'h0050_0093);

        // ---------------- 2: simultaneous store + fetch ----------------
        if_req  = 1'b1;
        if_addr = 32'h0000_0104;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_2000;
        d_wdata = 32'hDEAD_BEEF;
        d_wstrb = 4'hF;
        step();
        check_val("t2_d_addr",  mem_addr,  32'h2000);
        check_val("t2_d_we",    mem_we,    1);
        check_val("t2_d_wdata", mem_wdata, 32'hDEAD_BEEF);
        check_val("t2_d_wstrb", mem_wstrb, 4'hF);
        check_val("t2_wait1",   mem_wait,  1);
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_1111;
        step();
        check_val("t2_d_done",   d_done,   1);
        check_val("t2_st_rdata", d_rdata,  0);
        check_val("t2_wait2",    mem_wait, 1);
        d_req     = 1'b0;
        mem_ready = 1'b0;
        step();
        check_val("t2_f_req",   mem_req,   1);
        check_val("t2_f_addr",  mem_addr,  32'h104);
        check_val("t2_f_we",    mem_we,    0);
        check_val("t2_f_wstrb", mem_wstrb, 0);
        check_val("t2_wait3",   mem_wait,  1);
        mem_ready = 1'b1;
        mem_rdata = 32'h2222_2222;
        step();
        check_val("t2_if_done",  if_done,  1);
        check_val("t2_if_rdata", if_rdata, 32'h2222_2222);
        check_val("t2_wait_end", mem_wait, 0);
        if_req    = 1'b0;
        mem_ready = 1'b0;
        step();

        // ---------------- 3: starvation limit ----------------
        // if_req is lowered in each d_done cycle so the fetch cannot take
        // the idle slot that the completing load leaves behind.
        if_addr    = 32'h0000_0200;
        d_addr     = 32'h0000_3000;
        d_we       = 1'b0;
        d_wstrb    = 4'h0;
        mem_rdata  = 32'hCAFE_0000;
        if_req     = 1'b1;
        d_req      = 1'b1;
        order      = '0;
        n_grants   = 0;
        n_ddone    = 0;
        fetch_done = 1'b0;
        for (int cyc = 0; cyc < 80 && !(n_ddone == 6 && fetch_done); cyc++) begin
            prev_req = mem_req;
            step();
            if (mem_req && !prev_req) begin
                order = {order[5:0], (mem_addr == 32'h200)};
                n_grants++;
            end
            mem_ready = mem_req;
            if (d_done) begin
                n_ddone++;
                if (n_ddone == 6) d_req = 1'b0;
            end
            if (if_done) fetch_done = 1'b1;
            if_req = !fetch_done && !d_done;
        end
        check_val("t3_order",   order,    7'b0000100);
        check_val("t3_grants",  n_grants, 7);
        check_val("t3_ddone",   n_ddone,  6);
        check_val("t3_d_rdata", d_rdata,  32'hCAFE_0000);
        if_req    = 1'b0;
        mem_ready = 1'b0;
        step();

        // ---------------- 4: timeout abort ----------------
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_4000;
        step();
        check_val("t4_req", mem_req, 1);
        repeat (7) step();
        check_val("t4_req_held", mem_req, 1);
        check_val("t4_no_done",  d_done,  0);
        step();
        check_val("t4_req_drop", mem_req, 0);
        check_val("t4_d_done",   d_done,  1);
        check_val("t4_d_rdata",  d_rdata, 0);
        check_val("t4_bus_err",  bus_err, 1);
        d_req = 1'b0;
        step();
        check_val("t4_pulse",   d_done,  0);
        check_val("t4_sticky",  bus_err, 1);

        // ready on the terminal-count edge completes normally
        d_req  = 1'b1;
        d_addr = 32'h0000_4004;
        step();
        repeat (7) step();
        mem_ready = 1'b1;
        mem_rdata = 32'h5A5A_5A5A;
        step();
        check_val("t4b_d_done",  d_done,  1);
        check_val("t4b_d_rdata", d_rdata, 32'h5A5A_5A5A);
        d_req     = 1'b0;
        mem_ready = 1'b0;
        step();

        // ---------------- 5: async reset mid-transaction ----------------
        if_req  = 1'b1;
        if_addr = 32'h0000_0300;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_5000;
        d_wstrb = 4'h3;
        step();
        check_val("t5_d_addr", mem_addr, 32'h5000);
        #2;
        reset_in_n = 1'b0;
        #1;
        check_val("t5_req_async", mem_req,  0);
        check_val("t5_addr_rst",  mem_addr, 0);
        check_val("t5_err_rst",   bus_err,  0);
        d_req = 1'b0;
        #1;
        reset_in_n = 1'b1;
        step();
        check_val("t5_f_req",  mem_req,  1);
        check_val("t5_f_addr", mem_addr, 32'h300);
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();
        check_val("t5_if_done",  if_done,  1);
        check_val("t5_if_rdata", if_rdata, 32'h1234_5678);
        if_req    = 1'b0;
        mem_ready = 1'b0;
        step();

        // ---------------- 6: stray mem_ready while idle ----------------
        mem_ready = 1'b1;
        mem_rdata = 32'h9999_9999;
        for (int k = 0; k < 2; k++) begin
            step();
            check_val("t6_done", {if_done, d_done}, 0);
            check_val("t6_req",  mem_req,  0);
            check_val("t6_wait", mem_wait, 0);
        end
        check_val("t6_if_rdata", if_rdata, 32'h1234_5678);
        mem_ready = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
